// File: rtl/ps2_hex_entry_pkg.sv
// Shared scan-code constants, frame states and the hex-digit decode table.
// Defining PS2_KEYPAD_EN also accepts numeric-keypad make codes as digits 0-9.
package ps2_hex_entry_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} frame_state_t;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ESC   = 8'h76;

    // Returns {is_digit, nibble}.
    function automatic logic [4:0] hex_decode(input logic [7:0] code);
        logic [4:0] r;
        r = 5'b0;
        case (code)
            8'h45: r = {1'b1, 4'h0};
            8'h16: r = {1'b1, 4'h1};
            8'h1E: r = {1'b1, 4'h2};
            8'h26: r = {1'b1, 4'h3};
            8'h25: r = {1'b1, 4'h4};
            8'h2E: r = {1'b1, 4'h5};
            8'h36: r = {1'b1, 4'h6};
            8'h3D: r = {1'b1, 4'h7};
            8'h3E: r = {1'b1, 4'h8};
            8'h46: r = {1'b1, 4'h9};
            8'h1C: r = {1'b1, 4'hA};
            8'h32: r = {1'b1, 4'hB};
            8'h21: r = {1'b1, 4'hC};
            8'h23: r = {1'b1, 4'hD};
            8'h24: r = {1'b1, 4'hE};
            8'h2B: r = {1'b1, 4'hF};
`ifdef PS2_KEYPAD_EN
            8'h70: r = {1'b1, 4'h0};
            8'h69: r = {1'b1, 4'h1};
            8'h72: r = {1'b1, 4'h2};
            8'h7A: r = {1'b1, 4'h3};
            8'h6B: r = {1'b1, 4'h4};
            8'h73: r = {1'b1, 4'h5};
            8'h74: r = {1'b1, 4'h6};
            8'h6C: r = {1'b1, 4'h7};
            8'h75: r = {1'b1, 4'h8};
            8'h7D: r = {1'b1, 4'h9};
`endif
            default: r = 5'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 receive path: synchronisers, clock glitch filter, 11-bit frame FSM and
// mid-frame timeout. Emits a one-cycle byte_ok or frame_err per frame.
module ps2_rx_frame
    import ps2_hex_entry_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] rx_byte,
    output logic       byte_ok,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]    clk_sync, dat_sync;
    logic [FW-1:0] flt_cnt;
    logic          clk_flt, clk_flt_q;
    logic          fall, dat_s;

    frame_state_t  state, state_n;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par;
    logic [TW-1:0] to_cnt;
    logic          to_hit, stop_good;

    // Lines idle high, so synchronisers and filter reset to 1 to avoid a false edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            dat_sync  <= 2'b11;
            flt_cnt   <= '0;
            clk_flt   <= 1'b1;
            clk_flt_q <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            dat_sync  <= {dat_sync[0], ps2_dat};
            clk_flt_q <= clk_flt;
            if (clk_sync[1] == clk_flt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_flt <= clk_sync[1];
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    assign fall      = clk_flt_q & ~clk_flt;
    assign dat_s     = dat_sync[1];
    assign to_hit    = (state != ST_IDLE) && !fall && (to_cnt == TW'(TIMEOUT - 1));
    assign stop_good = (^{shreg, par}) && dat_s;
    assign rx_byte   = shreg;

    always_comb begin
        state_n = state;
        if (to_hit) begin
            state_n = ST_IDLE;
        end else if (fall) begin
            case (state)
                ST_IDLE:   if (!dat_s) state_n = ST_DATA;
                ST_DATA:   if (bit_cnt == 3'd7) state_n = ST_PARITY;
                ST_PARITY: state_n = ST_STOP;
                ST_STOP:   state_n = ST_IDLE;
                default:   state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            par       <= 1'b0;
            to_cnt    <= '0;
            byte_ok   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            byte_ok   <= fall && (state == ST_STOP) && stop_good;
            frame_err <= (fall && (state == ST_STOP) && !stop_good) || to_hit;
            to_cnt    <= (state == ST_IDLE || fall || to_hit) ? '0 : to_cnt + 1'b1;
            if (fall) begin
                case (state)
                    ST_IDLE:   bit_cnt <= '0;
                    ST_DATA: begin
                        shreg   <= {dat_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    ST_PARITY: par <= dat_s;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_hex_entry.sv
// PS/2 hex entry: turns typed hex keys into a 32-bit value with backspace,
// escape and enter editing; the live entry is exposed for echoing.
module ps2_hex_entry
    import ps2_hex_entry_pkg::*;
#(
    parameter int DIGITS     = 8,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    output logic [31:0] entry,
    output logic [3:0]  count,
    output logic [31:0] value,
    output logic        value_valid,
    output logic        frame_err
);

    localparam logic [31:0] MASK = 32'hFFFF_FFFF >> (32 - 4 * DIGITS);

    logic [7:0] rx_byte;
    logic       byte_ok;
    logic       brk, ext;
    logic [4:0] dec;

    ps2_rx_frame #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .rx_byte   (rx_byte),
        .byte_ok   (byte_ok),
        .frame_err (frame_err)
    );

    assign dec = hex_decode(rx_byte);

    always_ff @(posedge clk) begin
        if (rst) begin
            entry       <= '0;
            count       <= '0;
            value       <= '0;
            value_valid <= 1'b0;
            brk         <= 1'b0;
            ext         <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            if (byte_ok) begin
                if (brk) begin
                    // byte following F0 is a release: swallow it
                    brk <= 1'b0;
                    ext <= 1'b0;
                end else if (rx_byte == SC_EXT) begin
                    ext <= 1'b1;
                end else if (rx_byte == SC_BREAK) begin
                    brk <= 1'b1;
                    ext <= 1'b0;
                end else begin
                    ext <= 1'b0;
                    if (rx_byte == SC_ENTER) begin
                        value       <= entry;
                        value_valid <= 1'b1;
                        entry       <= '0;
                        count       <= '0;
                    end else if (!ext) begin
                        if (dec[4]) begin
                            if (count < 4'(DIGITS)) begin
                                entry <= {entry[27:0], dec[3:0]} & MASK;
                                count <= count + 1'b1;
                            end
                        end else if (rx_byte == SC_BKSP) begin
                            if (count != 4'd0) begin
                                entry <= entry >> 4;
                                count <= count - 1'b1;
                            end
                        end else if (rx_byte == SC_ESC) begin
                            entry <= '0;
                            count <= '0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_hex_entry.sv
// Bench for ps2_hex_entry: PS/2 frame driver, vector table, corner sequences and
// random keystrokes checked against a digit-list model.
module tb_ps2_hex_entry;

    localparam int DIGITS     = 8;
    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 1000;
    localparam int HALF       = 16;

    logic        clk, rst, ps2_clk, ps2_dat;
    logic [31:0] entry, value;
    logic [3:0]  count;
    logic        value_valid, frame_err;

    ps2_hex_entry #(.DIGITS(DIGITS), .FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_dat     (ps2_dat),
        .entry       (entry),
        .count       (count),
        .value       (value),
        .value_valid (value_valid),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int vv_cnt = 0, fe_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (value_valid) vv_cnt++;
            if (frame_err) fe_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: the entry is a list of typed digits.
    int          q[$];
    logic [31:0] m_value;
    int          m_vv;

    function automatic logic [31:0] m_entry();
        logic [31:0] e = 0;
        foreach (q[i]) e = e * 16 + q[i];
        return e;
    endfunction

    function automatic int digit_of(input logic [7:0] code);
        logic [7:0] main_tab [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                      8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
`ifdef PS2_KEYPAD_EN
        logic [7:0] kp_tab [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C,
                                    8'h75, 8'h7D};
        for (int i = 0; i < 10; i++) if (kp_tab[i] == code) return i;
`endif
        for (int i = 0; i < 16; i++) if (main_tab[i] == code) return i;
        return -1;
    endfunction

    task automatic model_key(input logic [7:0] code, input bit ex);
        int d;
        if (code == 8'h5A) begin
            m_value = m_entry();
            q.delete();
            m_vv++;
        end else if (!ex) begin
            d = digit_of(code);
            if (d >= 0) begin
                if (q.size() < DIGITS) q.push_back(d);
            end else if (code == 8'h66) begin
                if (q.size() > 0) void'(q.pop_back());
            end else if (code == 8'h76) begin
                q.delete();
            end
        end
    endtask

    // Drives the first nbits of an 11-bit frame; data changes while clock is high.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, ~(^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk) ps2_dat = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (HALF) @(negedge clk);
        ps2_dat = 1'b1;
    endtask

    task automatic key(input logic [7:0] code, input bit ex);
        if (ex) send_frame(8'hE0, 0, 11);
        send_frame(code, 0, 11);
        if (ex) send_frame(8'hE0, 0, 11);
        send_frame(8'hF0, 0, 11);
        send_frame(code, 0, 11);
        repeat (8) @(negedge clk);
        model_key(code, ex);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " entry"}, entry, m_entry());
        chk({tag, " count"}, {28'd0, count}, q.size());
        chk({tag, " value"}, value, m_value);
        chk({tag, " pulses"}, vv_cnt, m_vv);
    endtask

    typedef struct {
        logic [7:0]  code;
        bit          ex;
        logic [31:0] exp_entry;
        logic [3:0]  exp_count;
        logic [31:0] exp_value;
        int          exp_vv;
    } vec_t;

    vec_t tv[19];
    int   fe0, vv0, r;
    logic [7:0] code;

    initial begin
        tv[0]  = '{8'h16, 0, 32'h1,        4'd1, 32'h0,    0};
        tv[1]  = '{8'h1E, 0, 32'h12,       4'd2, 32'h0,    0};
        tv[2]  = '{8'h1C, 0, 32'h12A,      4'd3, 32'h0,    0};
        tv[3]  = '{8'h2B, 0, 32'h12AF,     4'd4, 32'h0,    0};
        tv[4]  = '{8'h5A, 0, 32'h0,        4'd0, 32'h12AF, 1};
        tv[5]  = '{8'h16, 0, 32'h1,        4'd1, 32'h12AF, 1};
        tv[6]  = '{8'h1E, 0, 32'h12,       4'd2, 32'h12AF, 1};
        tv[7]  = '{8'h26, 0, 32'h123,      4'd3, 32'h12AF, 1};
        tv[8]  = '{8'h66, 0, 32'h12,       4'd2, 32'h12AF, 1};
        tv[9]  = '{8'h76, 0, 32'h0,        4'd0, 32'h12AF, 1};
        tv[10] = '{8'h16, 0, 32'h1,        4'd1, 32'h12AF, 1};
        tv[11] = '{8'h1E, 0, 32'h12,       4'd2, 32'h12AF, 1};
        tv[12] = '{8'h26, 0, 32'h123,      4'd3, 32'h12AF, 1};
        tv[13] = '{8'h25, 0, 32'h1234,     4'd4, 32'h12AF, 1};
        tv[14] = '{8'h2E, 0, 32'h12345,    4'd5, 32'h12AF, 1};
        tv[15] = '{8'h36, 0, 32'h123456,   4'd6, 32'h12AF, 1};
        tv[16] = '{8'h3D, 0, 32'h1234567,  4'd7, 32'h12AF, 1};
        tv[17] = '{8'h3E, 0, 32'h12345678, 4'd8, 32'h12AF, 1};
        tv[18] = '{8'h46, 0, 32'h12345678, 4'd8, 32'h12AF, 1};

        m_value = 0;
        m_vv    = 0;
        rst = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset entry", entry, 0);
        chk("reset count", {28'd0, count}, 0);
        chk("reset value", value, 0);
        chk("reset value_valid", {31'd0, value_valid}, 0);
        chk("reset frame_err", {31'd0, frame_err}, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 19; i++) begin
            key(tv[i].code, tv[i].ex);
            chk($sformatf("vec%0d entry", i), entry, tv[i].exp_entry);
            chk($sformatf("vec%0d count", i), {28'd0, count}, {28'd0, tv[i].exp_count});
            chk($sformatf("vec%0d value", i), value, tv[i].exp_value);
            chk($sformatf("vec%0d pulses", i), vv_cnt, tv[i].exp_vv);
        end

        // Bad parity frame is reported and dropped.
        key(8'h76, 0);
        fe0 = fe_cnt;
        send_frame(8'h16, 1, 11);
        repeat (8) @(negedge clk);
        chk("parity frame_err", fe_cnt - fe0, 1);
        chk("parity entry", entry, 0);
        key(8'h16, 0);
        chk("after parity entry", entry, 32'h1);
        chk("parity no extra err", fe_cnt - fe0, 1);

        // Clock stalls mid-frame long enough to time out.
        key(8'h76, 0);
        fe0 = fe_cnt;
        send_frame(8'h45, 0, 5);
        repeat (TIMEOUT + 100) @(negedge clk);
        chk("timeout frame_err", fe_cnt - fe0, 1);
        key(8'h45, 0);
        chk("after timeout entry", entry, 0);
        chk("after timeout count", {28'd0, count}, 1);

        // Reset in the middle of a frame.
        key(8'h76, 0);
        key(8'h1C, 0);
        key(8'h32, 0);
        chk("pre-reset entry", entry, 32'hAB);
        send_frame(8'h16, 0, 3);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst entry", entry, 0);
        chk("midrst count", {28'd0, count}, 0);
        chk("midrst value", value, 0);
        chk("midrst value_valid", {31'd0, value_valid}, 0);
        chk("midrst frame_err", {31'd0, frame_err}, 0);
        rst = 1'b0;
        q.delete();
        m_value = 0;
        vv0 = vv_cnt;
        m_vv = vv_cnt;
        repeat (5) @(negedge clk);
        key(8'h5A, 1);
        chk("ext enter value", value, 0);
        chk("ext enter pulses", vv_cnt - vv0, 1);
        chk_model("ext enter");

        // Random keystrokes against the model.
        for (int n = 0; n < 24; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3, 4: code = 8'(digit_code($urandom_range(0, 15)));
                5:       code = 8'h66;
                6:       code = 8'h76;
                7:       code = 8'h5A;
                8:       begin
                    code = 8'($urandom_range(0, 255));
                    if (code == 8'hF0 || code == 8'hE0) code = 8'h00;
                end
                default: code = 8'(kp_code($urandom_range(0, 9)));
            endcase
            key(code, (r >= 7 && $urandom_range(0, 3) == 0));
            chk_model($sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic int digit_code(input int d);
        int t [16] = '{'h45, 'h16, 'h1E, 'h26, 'h25, 'h2E, 'h36, 'h3D,
                       'h3E, 'h46, 'h1C, 'h32, 'h21, 'h23, 'h24, 'h2B};
        return t[d];
    endfunction

    function automatic int kp_code(input int d);
        int t [10] = '{'h70, 'h69, 'h72, 'h7A, 'h6B, 'h73, 'h74, 'h6C, 'h75, 'h7D};
        return t[d];
    endfunction

endmodule
